// File: rtl/dm_responder.sv
// Word-addressed data-memory responder with REQ/ACK handshake and WAIT_CYC wait states.
// Optional macro DM_RESP_RANGE_CHK_EN adds the ERR port and out-of-range suppression.
module dm_responder #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ,
   input  logic              WE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] WDATA,
   output logic              ACK,
   output logic [DATA_W-1:0] RDATA,
   output logic              BUSY
`ifdef DM_RESP_RANGE_CHK_EN
   ,
   output logic              ERR
`endif
);

   localparam int unsigned IDXW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ack_q, ack_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic                commit;
   logic                oor;
   logic [IDXW-1:0]     idx;
   logic [DATA_W-1:0]   mem [DEPTH];

   assign idx    = addr_q[IDXW-1:0];
   assign commit = (state_q == S_WAIT) && (cnt_q == '0);

`ifdef DM_RESP_RANGE_CHK_EN
   assign oor = ({1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH));
`else
   assign oor = 1'b0;
   // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH.
   if (IDXW < ADDR_W) begin : g_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_q[ADDR_W-1:IDXW];
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Memory array carries no reset; a write in WAIT never reaches it if RST hits first.
   always_ff @(posedge CLK) begin
      if (commit && we_q && !oor) begin
         mem[idx] <= wdata_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (REQ) begin
               we_d    = WE;
               addr_d  = ADDR;
               wdata_d = WDATA;
               cnt_d   = 4'(WAIT_CYC);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ack_d   = commit;
      busy_d  = (state_d != S_IDLE);
      err_d   = commit && oor;
      rdata_d = rdata_q;
      if (commit && !we_q) begin
         rdata_d = oor ? '0 : mem[idx];
      end
   end

   assign ACK   = ack_q;
   assign RDATA = rdata_q;
   assign BUSY  = busy_q;
`ifdef DM_RESP_RANGE_CHK_EN
   assign ERR   = err_q;
`endif

endmodule
